// File: rtl/hack_boot_pkg.sv
// Shared definitions for the Hack boot loader.
//   ADDR_W_DEF : default ROM address width (ROM_DEPTH = 2**ADDR_W_DEF words)
//   HDR_BYTES  : length header bytes (LEN_HI, LEN_LO)
//   CK_BYTES   : trailing checksum bytes (non-zero only with BOOT_CHECKSUM_EN)
//   boot_state_t : loader FSM states; CK_HI/CK_LO exist only with BOOT_CHECKSUM_EN
// Build option: define BOOT_CHECKSUM_EN to expect and verify a 16-bit image checksum.
package hack_boot_pkg;

    localparam int ADDR_W_DEF = 15;
    localparam int ROM_DEPTH  = 2 ** ADDR_W_DEF;
    localparam int HDR_BYTES  = 2;
`ifdef BOOT_CHECKSUM_EN
    localparam int CK_BYTES   = 2;
`else
    localparam int CK_BYTES   = 0;
`endif

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_W_HI,
        ST_W_LO,
`ifdef BOOT_CHECKSUM_EN
        ST_CK_HI,
        ST_CK_LO,
`endif
        ST_RUN,
        ST_ERROR
    } boot_state_t;

    // States in which the loader is consuming image bytes.
    function automatic logic is_loading(input boot_state_t s);
        return (s != ST_IDLE) && (s != ST_RUN) && (s != ST_ERROR);
    endfunction

endpackage

// File: rtl/hack_boot_loader_word_asm.sv
// boot_word_assembler: joins the hi and lo image bytes into a 16-bit ROM word.
//   clk, reset  : system clock, async active-high reset
//   clear       : drop any latched hi byte (reload request)
//   hi_load     : capture byte_in as the high byte
//   lo_load     : combine latched hi byte with byte_in and present the word
//   byte_in     : incoming image byte
//   word        : last assembled word; holds until the next lo_load
//   word_valid  : one-cycle pulse in the cycle after lo_load
module boot_word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        hi_load,
    input  logic        lo_load,
    input  logic [7:0]  byte_in,
    output logic [15:0] word,
    output logic        word_valid
);

    logic [7:0] hi_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q       <= 8'd0;
            word       <= 16'd0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                hi_q <= 8'd0;
            end else begin
                if (hi_load) begin
                    hi_q <= byte_in;
                end
                if (lo_load) begin
                    word       <= {hi_q, byte_in};
                    word_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/hack_boot_loader.sv
// hack_boot_loader: holds the Hack CPU in reset, loads a length-prefixed
// program image from a byte stream into instruction ROM, then releases the CPU.
// A start pulse re-arms the loader for a new image without a system reset.
//   clk, reset           : system clock, async active-high reset
//   rx_valid/rx_data     : incoming image byte; rx_ready accepts it
//   start                : one-cycle reload request (ignored in IDLE)
//   rom_we/addr/wdata    : one write strobe per assembled word
//   cpu_reset            : high while not running a loaded image
//   busy / done / err    : loading / running / load failed
// Build option: BOOT_CHECKSUM_EN adds the trailing CK_HI/CK_LO checksum bytes.
//
// state   | meaning
// IDLE    | first cycle out of reset
// LEN_HI  | waiting for word-count high byte
// LEN_LO  | waiting for word-count low byte, range check
// W_HI    | waiting for word high byte
// W_LO    | waiting for word low byte, issues ROM write
// CK_HI   | waiting for checksum high byte (BOOT_CHECKSUM_EN)
// CK_LO   | waiting for checksum low byte, compare (BOOT_CHECKSUM_EN)
// RUN     | image loaded, CPU released
// ERROR   | bad length or checksum, CPU held in reset
module hack_boot_loader
    import hack_boot_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              start,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [15:0]       rom_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [63:0]     DEPTH_L = 64'd1 << ADDR_W;
    localparam logic [ADDR_W:0] IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};
`ifdef BOOT_CHECKSUM_EN
    localparam boot_state_t     ST_AFTER_WORDS = ST_CK_HI;
`else
    localparam boot_state_t     ST_AFTER_WORDS = ST_RUN;
`endif

    boot_state_t     state;
    boot_state_t     state_nxt;
    logic [7:0]      len_hi_q;
    logic [ADDR_W:0] len_q;
    logic [ADDR_W:0] index_q;
    logic [ADDR_W:0] index_nxt;
    logic [15:0]     sum_q;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]      ck_hi_q;
`endif
    logic [63:0]     n_wide;
    logic            start_eff;
    logic            acc;
    logic            len_over;
    logic            len_zero;
    logic            last_word;
    logic [15:0]     word;
    logic            word_valid;

    // start wins over a byte offered in the same cycle.
    assign start_eff = start && (state != ST_IDLE);
    assign acc       = rx_valid && rx_ready && !start;
    assign n_wide    = {48'd0, len_hi_q, rx_data};
    assign len_over  = n_wide > DEPTH_L;
    assign len_zero  = n_wide == 64'd0;
    assign index_nxt = index_q + IDX_ONE;
    assign last_word = index_nxt == len_q;

    boot_word_assembler u_word_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_eff),
        .hi_load    (acc && (state == ST_W_HI)),
        .lo_load    (acc && (state == ST_W_LO)),
        .byte_in    (rx_data),
        .word       (word),
        .word_valid (word_valid)
    );

    assign rom_we    = word_valid;
    assign rom_wdata = word;

    always_comb begin
        state_nxt = state;
        if (start_eff) begin
            state_nxt = ST_LEN_HI;
        end else begin
            unique case (state)
                ST_IDLE:   state_nxt = ST_LEN_HI;
                ST_LEN_HI: if (acc) state_nxt = ST_LEN_LO;
                ST_LEN_LO: begin
                    if (acc) begin
                        if (len_over)      state_nxt = ST_ERROR;
                        else if (len_zero) state_nxt = ST_AFTER_WORDS;
                        else               state_nxt = ST_W_HI;
                    end
                end
                ST_W_HI:   if (acc) state_nxt = ST_W_LO;
                ST_W_LO:   if (acc) state_nxt = last_word ? ST_AFTER_WORDS : ST_W_HI;
`ifdef BOOT_CHECKSUM_EN
                ST_CK_HI:  if (acc) state_nxt = ST_CK_LO;
                ST_CK_LO:  if (acc) state_nxt = ({ck_hi_q, rx_data} == sum_q) ? ST_RUN : ST_ERROR;
`endif
                ST_RUN:    state_nxt = ST_RUN;
                ST_ERROR:  state_nxt = ST_ERROR;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            rx_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            cpu_reset <= 1'b1;
            rom_addr  <= '0;
            len_hi_q  <= 8'd0;
            len_q     <= '0;
            index_q   <= '0;
            sum_q     <= 16'd0;
`ifdef BOOT_CHECKSUM_EN
            ck_hi_q   <= 8'd0;
`endif
        end else begin
            state     <= state_nxt;
            rx_ready  <= is_loading(state_nxt);
            busy      <= is_loading(state_nxt);
            done      <= state_nxt == ST_RUN;
            err       <= state_nxt == ST_ERROR;
            // Registered from the current state, so it releases one cycle
            // after RUN is entered, after the final ROM write strobe.
            cpu_reset <= state != ST_RUN;

            if (start_eff) begin
                index_q <= '0;
                sum_q   <= 16'd0;
            end else begin
                // The word lands one cycle after its low byte; CK_LO is at
                // least two cycles later, so the sum is complete by then.
                if (word_valid) begin
                    sum_q <= sum_q + word;
                end
                if (acc) begin
                    unique case (state)
                        ST_LEN_HI: len_hi_q <= rx_data;
                        ST_LEN_LO: begin
                            len_q   <= n_wide[ADDR_W:0];
                            index_q <= '0;
                        end
                        ST_W_LO: begin
                            rom_addr <= index_q[ADDR_W-1:0];
                            index_q  <= index_nxt;
                        end
`ifdef BOOT_CHECKSUM_EN
                        ST_CK_HI:  ck_hi_q <= rx_data;
`endif
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_hack_boot_loader.sv
module tb_hack_boot_loader;

    localparam int ADDR_W = 15;
`ifdef BOOT_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    typedef logic [7:0] bq_t[$];
    typedef int iq_t[$];
    typedef struct { int addr; int data; int cyc; } wr_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'd0;
    logic              start = 1'b0;
    logic              rx_ready;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_wdata;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              err;

    always #5 clk = ~clk;

    hack_boot_loader #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .start     (start),
        .rom_we    (rom_we),
        .rom_addr  (rom_addr),
        .rom_wdata (rom_wdata),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   fall_cyc = -1;
    int   rise_cyc = -1;
    int   start_cyc = 0;
    int   last_acc_cyc = 0;
    logic prev_cr = 1'b1;
    wr_t  wr_q[$];
    int   exp_w[$];
    bit   exp_err;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rom_we) wr_q.push_back('{addr: int'(rom_addr), data: int'(rom_wdata), cyc: cyc});
        if (prev_cr && !cpu_reset) fall_cyc = cyc;
        if (!prev_cr && cpu_reset) rise_cyc = cyc;
        prev_cr = cpu_reset;
    end

    // Reference: parse the byte image directly from the format rules.
    function automatic void run_model(input bq_t b);
        int n;
        int sum;
        int ck;
        exp_w.delete();
        exp_err = 1'b0;
        n = int'(b[0]) * 256 + int'(b[1]);
        if (n > (1 << ADDR_W)) begin
            exp_err = 1'b1;
            return;
        end
        sum = 0;
        for (int i = 0; i < n; i++) begin
            exp_w.push_back(int'(b[2 + 2*i]) * 256 + int'(b[3 + 2*i]));
            sum = (sum + exp_w[i]) % 65536;
        end
        if (CK_EN) begin
            ck = int'(b[2 + 2*n]) * 256 + int'(b[3 + 2*n]);
            exp_err = (ck != sum);
        end
    endfunction

    function automatic bq_t make_image(input iq_t w, input bit bad_ck);
        bq_t b;
        int  s = 0;
        b.push_back(8'(w.size() >> 8));
        b.push_back(8'(w.size()));
        foreach (w[i]) begin
            b.push_back(8'(w[i] >> 8));
            b.push_back(8'(w[i]));
            s = (s + w[i]) % 65536;
        end
        if (CK_EN) begin
            if (bad_ck) s = (s + 1) % 65536;
            b.push_back(8'(s >> 8));
            b.push_back(8'(s));
        end
        return b;
    endfunction

    task automatic send_bytes(input bq_t b);
        int i = 0;
        int guard = 0;
        while (i < b.size() && guard < 400) begin
            @(negedge clk);
            guard++;
            if ($urandom_range(3) == 0) begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
            end else begin
                rx_valid = 1'b1;
                rx_data  = b[i];
                if (rx_ready) begin
                    i++;
                    last_acc_cyc = cyc + 1;
                end
            end
        end
        total++;
        if (i < b.size()) begin
            bad++;
            $display("FAIL send_timeout: accepted=%0d required=%0d", i, b.size());
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        start_cyc = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        fall_cyc = -1;
        rise_cyc = -1;
        wr_q.delete();
    endtask

    task automatic wait_end();
        int guard = 0;
        while (!(done || err) && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (!(done || err)) begin
            bad++;
            $display("FAIL end_timeout: done=%0b err=%0b required one of them set", done, err);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic load(input bq_t b);
        pulse_start();
        send_bytes(b);
        wait_end();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({rx_ready, rom_we, rom_addr, rom_wdata, cpu_reset, busy, done, err} !==
            {1'b0, 1'b0, 15'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_vals: got rdy=%0b we=%0b a=%h d=%h cr=%0b b=%0b dn=%0b e=%0b required 0 0 0 0 1 0 0 0",
                     rx_ready, rom_we, rom_addr, rom_wdata, cpu_reset, busy, done, err);
        end
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({rx_ready, busy, cpu_reset, done} !== 4'b1110) begin
            bad++;
            $display("FAIL post_reset: rdy,busy,cr,done=%b required 1110", {rx_ready, busy, cpu_reset, done});
        end
    endtask

    task automatic test_basic();
        iq_t w;
        w.push_back(32'h1234);
        w.push_back(32'hABCD);
        load(make_image(w, 1'b0));
        total++;
        if (wr_q.size() != 2) begin
            bad++;
            $display("FAIL basic_count: got %0d required 2", wr_q.size());
        end else begin
            total++;
            if (wr_q[0].addr != 0 || wr_q[0].data != 32'h1234) begin
                bad++;
                $display("FAIL basic_w0: got %0d/%h required 0/1234", wr_q[0].addr, wr_q[0].data);
            end
            total++;
            if (wr_q[1].addr != 1 || wr_q[1].data != 32'hABCD) begin
                bad++;
                $display("FAIL basic_w1: got %0d/%h required 1/abcd", wr_q[1].addr, wr_q[1].data);
            end
            total++;
            if (fall_cyc != last_acc_cyc + 1 || fall_cyc <= wr_q[1].cyc) begin
                bad++;
                $display("FAIL basic_cpu_rel: fall=%0d required %0d (after write %0d)",
                         fall_cyc, last_acc_cyc + 1, wr_q[1].cyc);
            end
        end
        total++;
        if ({done, err, cpu_reset, busy, rx_ready} !== 5'b10000) begin
            bad++;
            $display("FAIL basic_status: dn,e,cr,b,rdy=%b required 10000", {done, err, cpu_reset, busy, rx_ready});
        end
        total++;
        if (rom_addr !== 15'd1 || rom_wdata !== 16'hABCD || rom_we !== 1'b0) begin
            bad++;
            $display("FAIL basic_hold: a=%h d=%h we=%0b required 1 abcd 0", rom_addr, rom_wdata, rom_we);
        end
    endtask

`ifdef BOOT_CHECKSUM_EN
    task automatic test_checksum();
        iq_t w;
        w.push_back(5);
        load(make_image(w, 1'b0));
        total++;
        if ({done, err, cpu_reset} !== 3'b100) begin
            bad++;
            $display("FAIL ck_good: dn,e,cr=%b required 100", {done, err, cpu_reset});
        end
        load(make_image(w, 1'b1));
        total++;
        if ({done, err, cpu_reset, busy, rx_ready} !== 5'b01100 || fall_cyc != -1) begin
            bad++;
            $display("FAIL ck_bad: dn,e,cr,b,rdy=%b fall=%0d required 01100 fall=-1",
                     {done, err, cpu_reset, busy, rx_ready}, fall_cyc);
        end
        total++;
        if (wr_q.size() != 1) begin
            bad++;
            $display("FAIL ck_bad_writes: got %0d required 1", wr_q.size());
        end
    endtask
`endif

    task automatic test_zero_len();
        iq_t w;
        load(make_image(w, 1'b0));
        total++;
        if ({done, err, cpu_reset} !== 3'b100 || wr_q.size() != 0 || fall_cyc != last_acc_cyc + 1) begin
            bad++;
            $display("FAIL zero_len: dn,e,cr=%b writes=%0d fall=%0d required 100 0 %0d",
                     {done, err, cpu_reset}, wr_q.size(), fall_cyc, last_acc_cyc + 1);
        end
    endtask

    task automatic test_len_overflow();
        bq_t b;
        b.push_back(8'h80);
        b.push_back(8'h01);
        load(b);
        total++;
        if ({done, err, cpu_reset, busy, rx_ready} !== 5'b01100 || wr_q.size() != 0) begin
            bad++;
            $display("FAIL len_over: dn,e,cr,b,rdy=%b writes=%0d required 01100 0",
                     {done, err, cpu_reset, busy, rx_ready}, wr_q.size());
        end
        b.delete();
        b.push_back(8'h80);
        b.push_back(8'h00);
        pulse_start();
        send_bytes(b);
        repeat (2) @(negedge clk);
        total++;
        if ({err, busy, rx_ready, cpu_reset} !== 4'b0111) begin
            bad++;
            $display("FAIL len_max: e,b,rdy,cr=%b required 0111", {err, busy, rx_ready, cpu_reset});
        end
    endtask

    task automatic test_reload();
        iq_t w;
        w.push_back(32'h1212);
        load(make_image(w, 1'b0));
        w.delete();
        w.push_back(32'h7FFF);
        load(make_image(w, 1'b0));
        total++;
        if (rise_cyc != start_cyc + 1) begin
            bad++;
            $display("FAIL reload_rise: got %0d required %0d", rise_cyc, start_cyc + 1);
        end
        total++;
        if (wr_q.size() != 1 || wr_q[0].addr != 0 || wr_q[0].data != 32'h7FFF) begin
            bad++;
            $display("FAIL reload_write: writes=%0d required single 0/7fff", wr_q.size());
        end
        total++;
        if (done !== 1'b1 || cpu_reset !== 1'b0 || fall_cyc != last_acc_cyc + 1) begin
            bad++;
            $display("FAIL reload_run: dn=%0b cr=%0b fall=%0d required 1 0 %0d",
                     done, cpu_reset, fall_cyc, last_acc_cyc + 1);
        end
    endtask

    task automatic test_start_discard();
        iq_t w;
        bq_t b;
        b.push_back(8'h00);
        b.push_back(8'h02);
        b.push_back(8'h12);
        b.push_back(8'h34);
        pulse_start();
        send_bytes(b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 8'hAB;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        rx_valid = 1'b0;
        wr_q.delete();
        w.push_back(32'h5566);
        send_bytes(make_image(w, 1'b0));
        wait_end();
        total++;
        if (done !== 1'b1 || wr_q.size() != 1) begin
            bad++;
            $display("FAIL discard_status: dn=%0b writes=%0d required 1 1", done, wr_q.size());
        end else begin
            total++;
            if (wr_q[0].addr != 0 || wr_q[0].data != 32'h5566) begin
                bad++;
                $display("FAIL discard_write: got %0d/%h required 0/5566", wr_q[0].addr, wr_q[0].data);
            end
        end
    endtask

    task automatic test_reset_mid();
        iq_t w;
        bq_t b;
        b.push_back(8'h00);
        b.push_back(8'h02);
        b.push_back(8'h11);
        b.push_back(8'h11);
        pulse_start();
        send_bytes(b);
        @(negedge clk);
        total++;
        if (wr_q.size() != 1) begin
            bad++;
            $display("FAIL mid_first_write: writes=%0d required 1", wr_q.size());
        end
        reset = 1'b1;
        #1;
        total++;
        if ({rx_ready, rom_we, rom_addr, rom_wdata, cpu_reset, busy, done, err} !==
            {1'b0, 1'b0, 15'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL mid_reset_vals: rdy=%0b we=%0b a=%h d=%h cr=%0b b=%0b required 0 0 0 0 1 0",
                     rx_ready, rom_we, rom_addr, rom_wdata, cpu_reset, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        w.push_back(32'h2121);
        w.push_back(32'h4343);
        load(make_image(w, 1'b0));
        total++;
        if (wr_q.size() != 2 || done !== 1'b1 || fall_cyc != last_acc_cyc + 1) begin
            bad++;
            $display("FAIL mid_reload: writes=%0d dn=%0b fall=%0d required 2 1 %0d",
                     wr_q.size(), done, fall_cyc, last_acc_cyc + 1);
        end else begin
            total++;
            if (wr_q[0].data != 32'h2121 || wr_q[1].addr != 1 || wr_q[1].data != 32'h4343) begin
                bad++;
                $display("FAIL mid_reload_data: got %h, %0d/%h required 2121, 1/4343",
                         wr_q[0].data, wr_q[1].addr, wr_q[1].data);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            iq_t w;
            bq_t b;
            if ($urandom_range(5) == 0) begin
                b.push_back(8'($urandom_range(255, 128)));
                b.push_back(8'($urandom_range(255, 1)));
            end else begin
                int n = $urandom_range(6, 1);
                for (int k = 0; k < n; k++) w.push_back(int'($urandom_range(65535)));
                b = make_image(w, 1'($urandom_range(1)));
            end
            run_model(b);
            load(b);
            total++;
            if (wr_q.size() != exp_w.size()) begin
                bad++;
                $display("FAIL rand_count[%0d]: got %0d required %0d", it, wr_q.size(), exp_w.size());
            end else begin
                for (int k = 0; k < exp_w.size(); k++) begin
                    total++;
                    if (wr_q[k].addr != k || wr_q[k].data != exp_w[k]) begin
                        bad++;
                        $display("FAIL rand_write[%0d.%0d]: got %0d/%h required %0d/%h",
                                 it, k, wr_q[k].addr, wr_q[k].data, k, exp_w[k]);
                    end
                end
            end
            total++;
            if (err !== exp_err || done !== !exp_err || cpu_reset !== exp_err) begin
                bad++;
                $display("FAIL rand_status[%0d]: e=%0b dn=%0b cr=%0b required err=%0b",
                         it, err, done, cpu_reset, exp_err);
            end
            if (!exp_err) begin
                total++;
                if (fall_cyc != last_acc_cyc + 1) begin
                    bad++;
                    $display("FAIL rand_release[%0d]: fall=%0d required %0d", it, fall_cyc, last_acc_cyc + 1);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
`ifdef BOOT_CHECKSUM_EN
        test_checksum();
`endif
        test_zero_len();
        test_len_overflow();
        test_reload();
        test_start_discard();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hack_boot_loader.md
# hack_boot_loader

Sequences Hack CPU start-up: holds the CPU in reset, receives a program image as a byte stream over a valid/ready handshake, writes it word-by-word into instruction ROM, then releases the CPU. Sits between the host-side byte source (UART receiver or testbench) and the cpu/ROM pair. It also owns the CPU's reset line and re-arms on request, so a new program can be loaded without a full system reset.

## Interface
- ADDR_W, 15, ROM address width; ROM depth is 2^ADDR_W words
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- rx_valid  in  1  byte available on rx_data
- rx_data  in  8  incoming byte
- rx_ready  out  1  loader accepts a byte this cycle
- start  in  1  one-cycle reload request
- rom_we  out  1  ROM write strobe, one cycle per word
- rom_addr  out  ADDR_W  ROM write address (word index)
- rom_wdata  out  16  ROM write data
- cpu_reset  out  1  drives cpu reset; high while loading
- busy  out  1  image transfer in progress
- done  out  1  image loaded, CPU running
- err  out  1  load failed; CPU held in reset

## Operation
- Image format: LEN_HI, LEN_LO (word count N, big-endian), then N words, each as hi byte then lo byte; with BOOT_CHECKSUM_EN, two trailing bytes CK_HI, CK_LO.
- Byte accepted on a rising clk edge where rx_valid & rx_ready.
- States: IDLE, LEN_HI, LEN_LO, W_HI, W_LO, CK_HI, CK_LO, RUN, ERROR.
- IDLE -> LEN_HI unconditionally on the first clock after reset release.
- LEN_LO accept: N > 2^ADDR_W -> ERROR; N = 0 -> CK_HI (macro on) or RUN; else W_HI with word index 0.
- W_LO accept: register rom_wdata = {hi, lo}, rom_addr = index; index increments; last word -> CK_HI or RUN, else W_HI.
- CK_LO accept: received sum equals running sum -> RUN, else ERROR.
- rx_ready = 1 in LEN_*, W_*, CK_*; 0 in IDLE, RUN, ERROR.
- busy = 1 in LEN_*, W_*, CK_*; done = 1 in RUN; err = 1 in ERROR.
- start in any state except IDLE -> LEN_HI, word index and sum cleared; a byte accepted in the same cycle is discarded (start wins).
- Address arithmetic: index is ADDR_W+1 bits internally; never wraps because N is range-checked.

## Timing
- Reset values: rx_ready 0, rom_we 0, rom_addr 0, rom_wdata 0, cpu_reset 1, busy 0, done 0, err 0.
- rom_we asserts for exactly one cycle, the cycle after the W_LO byte is accepted; rom_addr/rom_wdata are stable in that cycle and hold afterwards.
- cpu_reset is registered from state: falls one cycle after entering RUN, i.e. strictly after the final rom_we pulse. Rises one cycle after start is sampled in RUN.
- rx_valid may stay high across bytes; one byte per cycle maximum throughput.
- reset asserted mid-transfer: immediate return to IDLE, all outputs to reset values; partial ROM contents are not cleared.

## Configuration
- BOOT_CHECKSUM_EN defined: CK_HI/CK_LO states exist; 16-bit running sum mod 2^16 of all words; mismatch -> ERROR.
- Undefined: no checksum bytes expected, CK_* states absent; err asserts only on length overflow.

## Structure
- Package hack_boot_pkg: state enum, ROM_DEPTH = 2^ADDR_W default constant, header byte count.
- Sub-module boot_word_assembler: latches hi byte, emits 16-bit word plus a one-cycle word-valid; FSM and sum accumulator remain in the top.

## Test plan
- Bytes 00 02 12 34 AB CD (no macro) -> rom_we at addr 0 data 0x1234, addr 1 data 0xABCD; cpu_reset falls one cycle after second write; done = 1.
- Macro on, image 00 01 00 05 00 05 -> RUN, done = 1; same with checksum 00 06 -> ERROR, err = 1, cpu_reset stays 1.
- Length 80 01 (32769 > 2^15) -> ERROR after LEN_LO, no rom_we pulses.
- Length 00 00 (macro off) -> RUN immediately after LEN_LO, zero writes.
- In RUN, pulse start, resend 00 01 7F FF -> cpu_reset rises, single write 0x7FFF at addr 0, cpu_reset falls again.
- Assert reset after first word written -> outputs at reset values next edge; after release, full reload from LEN_HI succeeds.
